// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the memory pipeline stage.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  // Access size encodings; the unused code 2'd3 is handled as a full word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // FSM state encoding.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  // Byte-lane write enables for an access, sized for the widest (64-bit) datapath.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] off,
                                           input int lanes);
    logic [7:0] m;
    case (sz)
      SZ_BYTE: m = 8'h01 << off;
      SZ_HALF: m = 8'h03 << off;
      default: m = (lanes == 8) ? 8'hFF : 8'h0F;
    endcase
    return m;
  endfunction

  // Right-justify the addressed bytes of a word and sign- or zero-fill the rest.
  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [1:0] sz,
                                               input logic [2:0] off, input logic sx,
                                               input int lanes);
    logic [63:0] sh;
    logic [63:0] r;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: r = {{56{sx & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{48{sx & sh[15]}}, sh[15:0]};
      default: r = (lanes == 8) ? sh : {32'b0, sh[31:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Single-port synchronous data array with per-byte-lane write enables.
// Latency: read data is registered at the same edge that performs the access.
// Backpressure: none; rdata only changes on an enabled access, so it holds otherwise.
module mem_stage_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int LANES     = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [LANES-1:0]      we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Lane-masked write and read-before-write capture of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Pipeline memory stage: loads/stores with lane masking, ALU passthrough, misalign detect.
// Latency: memory ops LATENCY cycles, non-memory and misaligned ops 1 cycle.
// Backpressure: valid/ready both sides; outputs hold while out_valid && !out_ready.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [DATA_WIDTH-1:0] alu_res,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  state_t                state;
  logic [3:0]            cnt;      // cycles left until the result, counting the commit cycle

  // Request captured at acceptance for multi-cycle ops.
  logic                  req_ld;
  logic [LANES-1:0]      req_we;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [1:0]            req_sz;
  logic [OFF_W-1:0]      req_off;
  logic                  req_sx;

  // Output-side state; load data is formatted from the RAM read register.
  logic                  o_ld;
  logic [1:0]            o_sz;
  logic [OFF_W-1:0]      o_off;
  logic                  o_sx;
  logic [DATA_WIDTH-1:0] wb_q;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  ram_en;
  logic [LANES-1:0]      ram_we;
  logic [IDX_W-1:0]      ram_idx;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // Decode of the live request.
  logic                  mem_op, is_st, mis_raw, mis, accept;
  logic [OFF_W-1:0]      offset;
  logic [IDX_W-1:0]      idx;
  logic [LANES-1:0]      mask;
  logic [DATA_WIDTH-1:0] wdata_sh;

  assign mem_op   = mem_read | mem_write;
  assign is_st    = mem_write & ~mem_read;
  assign offset   = alu_res[OFF_W-1:0];
  assign idx      = alu_res[OFF_W+IDX_W-1:OFF_W];
  assign mask     = LANES'(lane_mask(size, 3'(offset), LANES));
  assign wdata_sh = store_data << {offset, 3'b000};
  assign mis      = mem_op & mis_raw;
  assign in_ready = (state == ST_IDLE) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Alignment check: halves need an even offset, words need offset zero.
  always_comb begin
    mis_raw = 1'b0;
    case (size)
      SZ_BYTE: mis_raw = 1'b0;
      SZ_HALF: mis_raw = offset[0];
      default: mis_raw = |offset;
    endcase
  end

  // Array port: commit from the latched request, or straight from the input when LATENCY is 1.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_idx   = req_idx;
    ram_wdata = req_wdata;
    if (!rst && !flush) begin
      if (state == ST_BUSY && cnt == 4'd1) begin
        ram_en = 1'b1;
        ram_we = req_we;
      end else if (LATENCY == 1 && accept && mem_op && !mis) begin
        ram_en    = 1'b1;
        ram_we    = is_st ? mask : '0;
        ram_idx   = idx;
        ram_wdata = wdata_sh;
      end
    end
  end

  mem_stage_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(ram_wdata),
    .rdata(rdata)
  );

  // FSM, request latch and output registers; reset beats flush beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      wb_q      <= '0;
      misalign  <= 1'b0;
      o_ld      <= 1'b0;
      o_sz      <= SZ_WORD;
      o_off     <= '0;
      o_sx      <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
        state     <= ST_IDLE;
        cnt       <= 4'd0;
      end else if (accept) begin
        if (mem_op && !mis && LATENCY > 1) begin
          state     <= ST_BUSY;
          cnt       <= 4'(LATENCY - 1);
          req_ld    <= mem_read;
          req_we    <= is_st ? mask : '0;
          req_idx   <= idx;
          req_wdata <= wdata_sh;
          req_addr  <= alu_res;
          req_sz    <= size;
          req_off   <= offset;
          req_sx    <= sign_ext;
        end else begin
          out_valid <= 1'b1;
          alu_out   <= alu_res;
          wb_q      <= mis ? '0 : alu_res;
          misalign  <= mis;
          o_ld      <= mem_read && !mis;
          o_sz      <= size;
          o_off     <= offset;
          o_sx      <= sign_ext;
        end
      end else if (state == ST_BUSY) begin
        if (cnt == 4'd1) begin
          state     <= ST_IDLE;
          cnt       <= 4'd0;
          out_valid <= 1'b1;
          alu_out   <= req_addr;
          wb_q      <= req_addr;
          misalign  <= 1'b0;
          o_ld      <= req_ld;
          o_sz      <= req_sz;
          o_off     <= req_off;
          o_sx      <= req_sx;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign wb_data = o_ld ? DATA_WIDTH'(load_extract(64'(rdata), o_sz, 3'(o_off), o_sx, LANES))
                        : wb_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe (32-bit, 1024 words, LATENCY=2).
// Latency: checks result cycle counts for memory, misaligned and passthrough ops.
// Backpressure: holds out_ready low and checks outputs and in_ready stay put.
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic [31:0] alu_res, store_data, alu_out, wb_data;
  logic        out_valid, out_ready, misalign;

  int checks = 0;
  int errors = 0;
  int r_lat;
  logic [31:0] r_wb, r_alu;
  logic        r_mis;
  logic        seen;

  mem_stage_pipe #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
    .alu_res(alu_res), .store_data(store_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for acceptance, then wait (bounded) for its result.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    alu_res = a; store_data = d;
    chk("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    r_lat = 1;
    while (!out_valid && r_lat < 20) begin
      tick();
      r_lat++;
    end
    r_wb = wb_data; r_alu = alu_out; r_mis = misalign;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'd0; sign_ext = 1'b0; alu_res = '0; store_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // ALU passthrough: one-cycle result
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0);
    chk("alu_lat", r_lat, 1);
    chk("alu_wb", r_wb, 32'h1234);
    chk("alu_out", r_alu, 32'h1234);

    // Word store then load at LATENCY=2
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    chk("st_lat", r_lat, 2);
    chk("st_wb_alu", r_wb, 32'h40);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("ld_lat", r_lat, 2);
    chk("ld_word", r_wb, 32'hDEADBEEF);

    // Byte store writes only lane 1
    do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h41, 32'h12345680);
    do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h41, 32'h0);
    chk("ld_byte_sx", r_wb, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
    chk("ld_byte_zx", r_wb, 32'h00000080);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("ld_word_merged", r_wb, 32'hDEAD80EF);
    do_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h42, 32'h0);
    chk("ld_half_sx", r_wb, 32'hFFFFDEAD);
    do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h40, 32'h0);
    chk("ld_half_zx", r_wb, 32'h000080EF);
    do_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    chk("ld_size3_word", r_wb, 32'hDEAD80EF);

    // Misaligned accesses: one cycle, no data, no write
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    chk("mis_lat", r_lat, 1);
    chk("mis_flag", {31'b0, r_mis}, 32'd1);
    chk("mis_wb", r_wb, 32'h0);
    chk("mis_alu", r_alu, 32'h42);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h41, 32'h0);
    chk("mis_half_flag", {31'b0, r_mis}, 32'd1);
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h43, 32'h0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("mis_no_write", r_wb, 32'hDEAD80EF);
    chk("aligned_mis_clear", {31'b0, r_mis}, 32'd0);

    // Read+write together behaves as a load
    do_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("rdwr_is_load", r_wb, 32'hDEAD80EF);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("rdwr_no_write", r_wb, 32'hDEAD80EF);

    // Flush one cycle into a store aborts it
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h22222222);
    tick();
    in_valid = 1'b1; mem_write = 1'b1; size = 2'd2; alu_res = 32'h80; store_data = 32'h11111111;
    tick();
    in_valid = 1'b0; mem_write = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("flush_no_out", {31'b0, seen}, 32'd0);
    // Flush alongside in_valid: not accepted
    in_valid = 1'b1; mem_write = 1'b1; flush = 1'b1;
    #1;
    chk("flush_blocks_ready", {31'b0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0; mem_write = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("flush_same_cycle_no_out", {31'b0, seen}, 32'd0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    chk("flush_no_write", r_wb, 32'h22222222);

    // Reset during BUSY aborts the store
    tick();
    in_valid = 1'b1; mem_write = 1'b1; size = 2'd2; alu_res = 32'h80; store_data = 32'h33333333;
    tick();
    in_valid = 1'b0; mem_write = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("rst_busy_no_out", {31'b0, out_valid}, 32'd0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    chk("rst_busy_no_write", r_wb, 32'h22222222);

    // Backpressure on a load result
    tick();
    out_ready = 1'b0;
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("bp_lat", r_lat, 2);
    in_valid = 1'b1; mem_read = 1'b0; alu_res = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_wb", wb_data, 32'hDEAD80EF);
      chk("bp_alu", alu_out, 32'h40);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", {31'b0, out_valid}, 32'd0);

    // Address wrap modulo DEPTH*LANES
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'd4100, 32'hCAFEF00D);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'd4, 32'h0);
    chk("wrap_data", r_wb, 32'hCAFEF00D);
    chk("wrap_alu", r_alu, 32'd4);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
